// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and default sizing for the UART TX scheduler.
//               Holds the scheduler FSM state encoding and the default
//               requester count / busy-timeout constants.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_BUSY_TIMEOUT = 16;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Purely combinational round-robin selector. Returns the first
//               asserted request found when searching upward (with wrap)
//               from the pointer index.
// Ports       : req_i       - request vector, one bit per requester
//               ptr_i       - index where the search starts
//               gnt_o       - selected requester index
//               gnt_valid_o - high when any request is asserted
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [$clog2(NUM_REQ)-1:0] gnt_o,
  output logic                       gnt_valid_o
);

  localparam int IDW = $clog2(NUM_REQ);

  int idx;

  // Walk offsets from farthest to nearest so the nearest hit is written last
  // and therefore wins.
  always_comb begin
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    idx         = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = (int'(ptr_i) + off) % NUM_REQ;
      if (req_i[idx[IDW-1:0]]) begin
        gnt_o       = idx[IDW-1:0];
        gnt_valid_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_scheduler
// Description : Shares one UART transmitter between NUM_REQ byte streams.
//               A packet owner keeps the transmitter locked until its byte
//               marked last has been sent; packet owners rotate round-robin.
// Ports       : clk, rst_n           - clock, async active-low reset
//               req_valid/data/last  - per-requester byte stream
//               req_ready            - per-requester accept
//               tx_start, tx_data    - start pulse and byte to transmitter
//               tx_busy              - transmitter busy
//               clear_err            - clears the sticky timeout flag
//               grant_id, locked     - current owner, packet in progress
//               timeout_err          - sticky busy-never-rose error
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  input  logic                       clear_err,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       locked,
  output logic                       timeout_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(BUSY_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             locked_q, locked_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [7:0]       txd_q, txd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [7:0]       req_byte [NUM_REQ];
  logic [IDW-1:0]   arb_gnt;
  logic             arb_valid;
  logic [IDW-1:0]   cand;
  logic             cand_valid;
  logic             accept;
  logic             busy_timeout;
  logic [IDW-1:0]   next_ptr;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_byte[gi] = req_data[gi*8 +: 8];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .gnt_o       (arb_gnt),
    .gnt_valid_o (arb_valid)
  );

  // While a packet is open only the owner may continue; the arbiter result
  // is ignored.
  assign cand       = locked_q ? grant_q : arb_gnt;
  assign cand_valid = locked_q ? req_valid[grant_q] : arb_valid;
  assign accept     = (state_q == ST_IDLE) && cand_valid && !tx_busy;
  assign next_ptr   = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  // Gated by rst_n so ready drops the instant reset asserts, before the
  // flops have been observed.
  always_comb begin
    req_ready = '0;
    if (accept && rst_n) begin
      req_ready[cand] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    locked_d     = locked_q;
    last_d       = last_q;
    txd_d        = txd_q;
    cnt_d        = cnt_q;
    busy_timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          txd_d    = req_byte[cand];
          last_d   = req_last[cand];
          locked_d = 1'b1;
          grant_d  = cand;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          // Last of BUSY_TIMEOUT quiet cycles: give up on this packet.
          busy_timeout = 1'b1;
          locked_d     = 1'b0;
          ptr_d        = next_ptr;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
          if (last_q) begin
            locked_d = 1'b0;
            ptr_d    = next_ptr;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A timeout in the same cycle as clear_err must still be reported.
    if (busy_timeout) begin
      err_d = 1'b1;
    end else if (clear_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      locked_q <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      txd_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      locked_q <= locked_d;
      last_q   <= last_d;
      err_q    <= err_d;
      txd_q    <= txd_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tx_start    = (state_q == ST_START);
  assign tx_data     = txd_q;
  assign grant_id    = grant_q;
  assign locked      = locked_q;
  assign timeout_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_scheduler
// Description : Directed self-checking bench for uart_tx_scheduler with a
//               transmitter model, per-requester byte queues and a tx_start
//               log.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

  localparam int NR = 4;
  localparam int BT = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR*8-1:0] req_data = '0;
  logic [NR-1:0] req_last = '0;
  logic [NR-1:0] req_ready;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic          clear_err = 1'b0;
  logic [1:0]    grant_id;
  logic          locked;
  logic          timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_scheduler #(
    .NUM_REQ      (NR),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .clear_err   (clear_err),
    .grant_id    (grant_id),
    .locked      (locked),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy for busy_len cycles after each start pulse.
  int busy_len = 10;
  bit model_en = 1'b1;
  int bcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bcnt <= 0;
    else if (tx_start && model_en) bcnt <= busy_len;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0);

  // Per-requester byte queues {last, data}.
  logic [8:0] mem [NR][32];
  int head [NR];
  int tail [NR];
  bit [NR-1:0] hs = '0;

  initial begin
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (hs[i] && rst_n && head[i] != tail[i]) head[i] = head[i] + 1;
    end
    for (int i = 0; i < NR; i++) begin
      if (head[i] != tail[i]) begin
        req_valid[i]      = 1'b1;
        req_data[i*8 +: 8] = mem[i][head[i] % 32][7:0];
        req_last[i]       = mem[i][head[i] % 32][8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
    #1;
    hs = req_valid & req_ready;
  end

  // tx_start log.
  logic [7:0] log_d [64];
  logic [1:0] log_g [64];
  int         log_t [64];
  logic       log_l [64];
  int nlog = 0;
  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      log_d[nlog % 64] = tx_data;
      log_g[nlog % 64] = grant_id;
      log_t[nlog % 64] = cyc;
      log_l[nlog % 64] = locked;
      nlog = nlog + 1;
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    mem[r][tail[r] % 32] = {l, d};
    tail[r] = tail[r] + 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    nlog = 0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    bit empty;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      step();
      empty = 1'b1;
      for (int i = 0; i < NR; i++) if (head[i] != tail[i]) empty = 1'b0;
      if (empty && !locked && !tx_busy && !tx_start) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    push(0, 8'hAA, 1'b1);
    step();
    step();
    n_checks += 6;
    if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
    if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    head[0] = tail[0];
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [7:0] exp_d [3];
    bit ok;
    exp_d[0] = 8'h41; exp_d[1] = 8'h42; exp_d[2] = 8'h43;
    do_reset();
    busy_len = 10;
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b0);
    push(0, 8'h43, 1'b1);
    wait_drain(400, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_drain: got timeout expected drained"); end
    n_checks++;
    if (nlog !== 3) begin n_fail++; $display("FAIL single_count: got %0d expected 3", nlog); end
    for (int i = 0; i < 3; i++) begin
      n_checks += 3;
      if (log_d[i] !== exp_d[i]) begin n_fail++; $display("FAIL single_data[%0d]: got %h expected %h", i, log_d[i], exp_d[i]); end
      if (log_g[i] !== 2'd0) begin n_fail++; $display("FAIL single_gid[%0d]: got %0d expected 0", i, log_g[i]); end
      if (log_l[i] !== 1'b1) begin n_fail++; $display("FAIL single_locked[%0d]: got %b expected 1", i, log_l[i]); end
    end
    for (int i = 1; i < 3; i++) begin
      n_checks++;
      if (log_t[i] - log_t[i-1] !== 13) begin n_fail++; $display("FAIL single_spacing[%0d]: got %0d expected 13", i, log_t[i] - log_t[i-1]); end
    end
    n_checks += 2;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL single_unlock: got %b expected 0", locked); end
    if (tx_data !== 8'h43) begin n_fail++; $display("FAIL single_tx_data_hold: got %h expected 43", tx_data); end
  endtask

  task automatic test_contention();
    logic [7:0] exp_d [4];
    logic [1:0] exp_g [4];
    bit ok;
    exp_d[0] = 8'h11; exp_d[1] = 8'h12; exp_d[2] = 8'h21; exp_d[3] = 8'h22;
    exp_g[0] = 2'd1;  exp_g[1] = 2'd1;  exp_g[2] = 2'd2;  exp_g[3] = 2'd2;
    do_reset();
    busy_len = 5;
    push(1, 8'h11, 1'b0);
    push(1, 8'h12, 1'b1);
    push(2, 8'h21, 1'b0);
    push(2, 8'h22, 1'b1);
    wait_drain(400, ok);
    n_checks += 2;
    if (!ok) begin n_fail++; $display("FAIL contention_drain: got timeout expected drained"); end
    if (nlog !== 4) begin n_fail++; $display("FAIL contention_count: got %0d expected 4", nlog); end
    for (int i = 0; i < 4; i++) begin
      n_checks += 2;
      if (log_d[i] !== exp_d[i]) begin n_fail++; $display("FAIL contention_data[%0d]: got %h expected %h", i, log_d[i], exp_d[i]); end
      if (log_g[i] !== exp_g[i]) begin n_fail++; $display("FAIL contention_gid[%0d]: got %0d expected %0d", i, log_g[i], exp_g[i]); end
    end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_d [5];
    logic [1:0] exp_g [5];
    bit ok;
    exp_d[0] = 8'hA0; exp_d[1] = 8'hB0; exp_d[2] = 8'hC0; exp_d[3] = 8'hD0; exp_d[4] = 8'hA1;
    exp_g[0] = 2'd0;  exp_g[1] = 2'd1;  exp_g[2] = 2'd2;  exp_g[3] = 2'd3;  exp_g[4] = 2'd0;
    do_reset();
    busy_len = 3;
    push(0, 8'hA0, 1'b1);
    push(0, 8'hA1, 1'b1);
    push(1, 8'hB0, 1'b1);
    push(2, 8'hC0, 1'b1);
    push(3, 8'hD0, 1'b1);
    wait_drain(400, ok);
    n_checks += 2;
    if (!ok) begin n_fail++; $display("FAIL fairness_drain: got timeout expected drained"); end
    if (nlog !== 5) begin n_fail++; $display("FAIL fairness_count: got %0d expected 5", nlog); end
    for (int i = 0; i < 5; i++) begin
      n_checks += 2;
      if (log_g[i] !== exp_g[i]) begin n_fail++; $display("FAIL fairness_gid[%0d]: got %0d expected %0d", i, log_g[i], exp_g[i]); end
      if (log_d[i] !== exp_d[i]) begin n_fail++; $display("FAIL fairness_data[%0d]: got %h expected %h", i, log_d[i], exp_d[i]); end
    end
  endtask

  task automatic test_timeout();
    bit seen;
    int n;
    model_en = 1'b0;
    nlog = 0;
    push(2, 8'h5A, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (tx_start) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL timeout_start: got no tx_start expected pulse"); end
    step();  // tx_start has just fallen
    n = 0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      step();
      if (timeout_err) begin seen = 1'b1; n = k; end
    end
    n_checks += 2;
    if (n !== BT) begin n_fail++; $display("FAIL timeout_delay: got %0d expected %0d", n, BT); end
    if (locked !== 1'b0) begin n_fail++; $display("FAIL timeout_locked: got %b expected 0", locked); end
    repeat (3) step();
    n_checks++;
    if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b expected 1", timeout_err); end
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    n_checks++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b expected 0", timeout_err); end

    // Timeout coinciding with a held clear_err.
    clear_err = 1'b1;
    push(3, 8'h6B, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (tx_start) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL timeout2_start: got no tx_start expected pulse"); end
    step();
    repeat (BT - 1) step();
    n_checks++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout2_early: got %b expected 0", timeout_err); end
    step();
    n_checks++;
    if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout2_wins_over_clear: got %b expected 1", timeout_err); end
    clear_err = 1'b0;
    step();
    n_checks++;
    if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout2_hold: got %b expected 1", timeout_err); end
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit ok;
    do_reset();
    busy_len = 6;
    push(1, 8'h31, 1'b0);
    push(1, 8'h32, 1'b0);
    push(1, 8'h33, 1'b0);
    push(1, 8'h34, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      step();
      if (nlog >= 2) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL resetmid_second_byte: got %0d starts expected 2", nlog); end
    repeat (3) step();  // now in WAIT_DONE of byte 2
    rst_n = 1'b0;
    #1;
    n_checks += 6;
    if (tx_start !== 1'b0) begin n_fail++; $display("FAIL resetmid_tx_start: got %b expected 0", tx_start); end
    if (tx_data !== 8'h00) begin n_fail++; $display("FAIL resetmid_tx_data: got %h expected 00", tx_data); end
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL resetmid_req_ready: got %b expected 0000", req_ready); end
    if (grant_id !== 2'd0) begin n_fail++; $display("FAIL resetmid_grant_id: got %0d expected 0", grant_id); end
    if (locked !== 1'b0) begin n_fail++; $display("FAIL resetmid_locked: got %b expected 0", locked); end
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL resetmid_timeout_err: got %b expected 0", timeout_err); end
    head[1] = tail[1];
    step();
    step();
    rst_n = 1'b1;
    step();
    nlog = 0;
    push(3, 8'h71, 1'b0);
    push(3, 8'h72, 1'b1);
    wait_drain(300, ok);
    n_checks += 6;
    if (!ok) begin n_fail++; $display("FAIL resetmid_drain: got timeout expected drained"); end
    if (nlog !== 2) begin n_fail++; $display("FAIL resetmid_count: got %0d expected 2", nlog); end
    if (log_d[0] !== 8'h71) begin n_fail++; $display("FAIL resetmid_data0: got %h expected 71", log_d[0]); end
    if (log_d[1] !== 8'h72) begin n_fail++; $display("FAIL resetmid_data1: got %h expected 72", log_d[1]); end
    if (log_g[0] !== 2'd3) begin n_fail++; $display("FAIL resetmid_gid0: got %0d expected 3", log_g[0]); end
    if (log_g[1] !== 2'd3) begin n_fail++; $display("FAIL resetmid_gid1: got %0d expected 3", log_g[1]); end
  endtask

  task automatic test_owner_stall();
    logic [7:0] exp_d [4];
    logic [1:0] exp_g [4];
    bit ok;
    exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h03; exp_d[3] = 8'h91;
    exp_g[0] = 2'd0;  exp_g[1] = 2'd0;  exp_g[2] = 2'd0;  exp_g[3] = 2'd1;
    do_reset();
    busy_len = 4;
    push(0, 8'h01, 1'b0);
    push(1, 8'h91, 1'b1);
    repeat (40) step();
    n_checks += 5;
    if (nlog !== 1) begin n_fail++; $display("FAIL stall_count: got %0d expected 1", nlog); end
    if (locked !== 1'b1) begin n_fail++; $display("FAIL stall_locked: got %b expected 1", locked); end
    if (grant_id !== 2'd0) begin n_fail++; $display("FAIL stall_grant: got %0d expected 0", grant_id); end
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready: got %b expected 0000", req_ready); end
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL stall_no_timeout: got %b expected 0", timeout_err); end
    push(0, 8'h02, 1'b0);
    push(0, 8'h03, 1'b1);
    wait_drain(400, ok);
    n_checks += 2;
    if (!ok) begin n_fail++; $display("FAIL stall_drain: got timeout expected drained"); end
    if (nlog !== 4) begin n_fail++; $display("FAIL stall_total: got %0d expected 4", nlog); end
    for (int i = 0; i < 4; i++) begin
      n_checks += 2;
      if (log_d[i] !== exp_d[i]) begin n_fail++; $display("FAIL stall_data[%0d]: got %h expected %h", i, log_d[i], exp_d[i]); end
      if (log_g[i] !== exp_g[i]) begin n_fail++; $display("FAIL stall_gid[%0d]: got %0d expected %0d", i, log_g[i], exp_g[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_owner_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one transmitter.
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 16: max cycles to wait for tx_busy to rise after tx_start.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid  in  NUM_REQ  per-requester byte valid.
REQ-006 SHALL have port req_data  in  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 SHALL have port req_last  in  NUM_REQ  marks final byte of a packet.
REQ-008 SHALL have port req_ready  out  NUM_REQ  byte accepted when valid&ready are both high on the same cycle.
REQ-009 SHALL have port tx_start  out  1  one-cycle start pulse to the transmitter.
REQ-010 SHALL have port tx_data  out  8  registered byte to the transmitter.
REQ-011 SHALL have port tx_busy  in  1  transmitter busy.
REQ-012 SHALL have port clear_err  in  1  clears timeout_err.
REQ-013 SHALL have ports grant_id  out  $clog2(NUM_REQ)  current owner; locked  out  1  packet in progress; timeout_err  out  1  sticky error.

Function
REQ-014 SHALL implement FSM states IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE, unlocked: SHALL select the requester with req_valid high, searching round-robin from the index after the last packet owner; with none valid, no state change.
REQ-016 IDLE, locked: SHALL consider only grant_id and ignore other requesters even if they are valid.
REQ-017 IDLE: SHALL assert req_ready[grant] combinationally only when that requester is valid and tx_busy is low; all other req_ready bits SHALL be 0 in every state.
REQ-018 On accept: SHALL register tx_data and req_last, set locked=1 and grant_id, then go to START.
REQ-019 START: SHALL drive tx_start=1 for exactly one cycle, i.e. one cycle after accept, then go to WAIT_BUSY.
REQ-020 WAIT_BUSY: SHALL go to WAIT_DONE on tx_busy=1.
REQ-021 WAIT_BUSY: after BUSY_TIMEOUT cycles without tx_busy=1, SHALL set timeout_err=1, clear locked, advance the round-robin pointer, and go to IDLE.
REQ-022 WAIT_DONE: on tx_busy=0, SHALL go to IDLE; if the registered last=1, SHALL also clear locked and set the round-robin pointer to grant_id+1 mod NUM_REQ.
REQ-023 Owner dropping req_valid mid-packet: SHALL hold the lock indefinitely, with no timeout.
REQ-024 tx_data SHALL stay stable from accept until the next accept.
REQ-025 timeout_err SHALL be sticky; clear_err SHALL clear it; if a timeout and clear_err occur on the same cycle, the timeout wins.
REQ-026 A single-byte packet (last on the first byte) SHALL lock and unlock within one transaction.
REQ-027 Throughput: at most one byte accepted per transmitter busy period; minimum byte-to-byte spacing = busy length + 3 cycles.

Reset
REQ-028 rst_n low SHALL immediately force: state=IDLE, tx_start=0, tx_data=0, req_ready=0, grant_id=0, locked=0, timeout_err=0, round-robin pointer=0, timeout counter=0.
REQ-029 Reset mid-packet SHALL abandon the packet; after reset deassertion, arbitration restarts from requester 0.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum and the default NUM_REQ and BUSY_TIMEOUT constants.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; outputs: grant index, grant valid), purely combinational.
REQ-032 The timeout counter SHALL be $clog2(BUSY_TIMEOUT+1) bits wide, reset on entry to WAIT_BUSY.

Verification
REQ-033 Single requester: req 0 sends a 3-byte packet 0x41,0x42,0x43(last), transmitter model busy 10 cycles -> three tx_start pulses carrying those bytes in order; locked falls after the third busy ends.
REQ-034 Contention: reqs 1 and 2 both valid with 2-byte packets after reset -> req 1's full packet, then req 2's; no interleaving; grant_id sequence 1,1,2,2.
REQ-035 Fairness: all 4 requesters continuously sending 1-byte packets -> grant order 0,1,2,3,0.
REQ-036 Timeout: tx_busy tied low -> timeout_err=1 exactly BUSY_TIMEOUT cycles after tx_start; locked=0; clear_err clears it the next cycle.
REQ-037 Reset mid-packet: rst_n pulsed low during WAIT_DONE of byte 2 of 4 -> all outputs at reset values while low; after release, a new packet from req 3 is served normally.
REQ-038 Owner stall: req 0 drops valid after byte 1, req 1 valid -> no grant to req 1 until req 0 finishes with last.
